// File: rtl/wisc_pkg.sv
// Shared WISC-F18 fetch definitions: opcode field layout, PC step and the
// fetch FSM state encoding.
package wisc_pkg;

    localparam int         OPC_W   = 4;
    localparam logic [3:0] OPC_HLT = 4'hF;
    localparam int         PC_STEP = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Show-ahead FIFO holding {pc, instruction} pairs; the head is visible
// combinationally so decode sees a word the cycle after it is pushed.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    // Flush wins over everything, so a redirecting cycle never moves data.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // The issue credit must make this impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(do_push && full && !do_pop));

endmodule

// File: rtl/ifetch_prefetch.sv
// Decoupled instruction prefetcher: in-order requests to a variable-latency
// memory, credit-limited queue, redirect flush and HLT stop.
module ifetch_prefetch
    import wisc_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSN_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = wisc_pkg::PC_STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_valid,
    input  logic [INSN_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INSN_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    output logic [ADDR_W-1:0] ins_pc_next,
    output logic              fetch_halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int Q_W   = ADDR_W + INSN_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
    logic [CNT_W-1:0]  inflight_reg, inflight_next;
    logic [CNT_W-1:0]  drop_reg, drop_next;
    logic              started_reg;

    logic [Q_W-1:0]    q_head;
    logic [Q_W-1:0]    q_wdata;
    logic [CNT_W-1:0]  q_count;
    logic              q_full, q_empty, q_push, q_pop;
    logic [CNT_W:0]    credit_used;
    logic              accept;

    // Queued words plus outstanding requests may never exceed the queue size.
    assign credit_used = {1'b0, q_count} + {1'b0, inflight_reg};
    assign imem_req    = started_reg && (state_reg == ST_RUN) && !redirect_valid && !q_full
                         && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr   = fetch_pc_reg;
    assign accept      = imem_req && imem_ready;
    assign q_wdata     = {resp_pc_reg, imem_data};

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        resp_pc_next  = resp_pc_reg;
        drop_next     = drop_reg;
        q_push        = 1'b0;
        q_pop         = 1'b0;
        inflight_next = inflight_reg + {{(CNT_W-1){1'b0}}, accept}
                                     - {{(CNT_W-1){1'b0}}, imem_valid};
        if (redirect_valid) begin
            // Everything still outstanding, including this cycle's response, is stale.
            fetch_pc_next = redirect_pc;
            resp_pc_next  = redirect_pc;
            drop_next     = inflight_next;
            state_next    = ST_RUN;
        end else begin
            if (accept) begin
                fetch_pc_next = fetch_pc_reg + STEP;
            end
            q_pop = !q_empty && ins_ready;
            if (imem_valid) begin
                if (drop_reg != '0) begin
                    drop_next = drop_reg - 1'b1;
                end else begin
                    q_push       = 1'b1;
                    resp_pc_next = resp_pc_reg + STEP;
                    if (imem_data[INSN_W-1 -: OPC_W] == OPC_HLT) begin
                        state_next = ST_HALT;
                        drop_next  = inflight_next;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            inflight_reg <= '0;
            drop_reg     <= '0;
            started_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            resp_pc_reg  <= resp_pc_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
            started_reg  <= 1'b1;
        end
    end

    fetch_queue #(
        .WIDTH (Q_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Head fields are forced to reset-like values when empty so stale RAM never shows.
    assign ins_valid    = !q_empty;
    assign ins_data     = q_empty ? '0 : q_head[INSN_W-1:0];
    assign ins_pc       = q_empty ? RESET_PC : q_head[Q_W-1 -: ADDR_W];
    assign ins_pc_next  = ins_pc + STEP;
    assign fetch_halted = (state_reg == ST_HALT);

endmodule
